// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution window MAC.
// Pixel/coefficient typedefs plus the unsigned 8-bit saturator.
package conv_pkg;

   localparam int PIXEL_W = 8;
   localparam int COEF_W  = 8;
   localparam int SAT_W   = 32;

   typedef logic [PIXEL_W-1:0] pixel_t;
   typedef logic signed [COEF_W-1:0] coef_t;

   function automatic pixel_t sat_u8(input logic signed [SAT_W-1:0] acc);
      if (acc < 0)
         return '0;
      else if (acc > 255)
         return 8'hFF;
      else
         return acc[PIXEL_W-1:0];
   endfunction

endpackage

// File: rtl/conv_raster_tracker.sv
// Raster row/col tracking for the convolution window MAC.
// Flags complete windows, the frame's final beat, and frame_done.
module conv_raster_tracker #(
   parameter int KERNEL_SIZE = 3,
   parameter int ROW_WIDTH   = 100,
   parameter int COL_HEIGHT  = 100
) (
   input  logic clk,
   input  logic reset,
   input  logic in_valid,
   input  logic frame_start,
   output logic complete,
   output logic last,
   output logic frame_done
);

   localparam int RW = (COL_HEIGHT > 1) ? $clog2(COL_HEIGHT) : 1;
   localparam int CW = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
   localparam logic [RW-1:0] ROW_LAST = RW'(COL_HEIGHT - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(ROW_WIDTH - 1);
   localparam logic [RW-1:0] ROW_MIN  = RW'(KERNEL_SIZE - 1);
   localparam logic [CW-1:0] COL_MIN  = CW'(KERNEL_SIZE - 1);

   logic [RW-1:0] row_q, row_d, pos_row;
   logic [CW-1:0] col_q, col_d, pos_col;

   always_comb begin
      pos_row  = frame_start ? '0 : row_q;
      pos_col  = frame_start ? '0 : col_q;
      row_d    = row_q;
      col_d    = col_q;
      complete = 1'b0;
      last     = 1'b0;
      if (in_valid) begin
         complete = (pos_row >= ROW_MIN) && (pos_col >= COL_MIN);
         last     = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
         if (pos_col == COL_LAST) begin
            col_d = '0;
            row_d = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
         end else begin
            col_d = pos_col + 1'b1;
            row_d = pos_row;
         end
      end else if (frame_start) begin
         row_d = '0;
         col_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_q      <= '0;
         col_q      <= '0;
         frame_done <= 1'b0;
      end else begin
         row_q      <= row_d;
         col_q      <= col_d;
         frame_done <= last;
      end
   end

endmodule

// File: rtl/conv_window_mac.sv
// KxK window multiply-accumulate: multiply, sum, scale+saturate (3 stages).
// Define CONV_ROUND_EN to round half up before the scaling shift.
module conv_window_mac
   import conv_pkg::*;
#(
   parameter int KERNEL_SIZE = 3,
   parameter int ROW_WIDTH   = 100,
   parameter int COL_HEIGHT  = 100,
   parameter int COEF_WIDTH  = 8,
   parameter int SHIFT       = 4
) (
   input  logic clk,
   input  logic reset,
   input  pixel_t [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0] window,
   input  logic in_valid,
   input  logic frame_start,
   input  logic coef_we,
   input  logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0] coef_addr,
   input  logic signed [COEF_WIDTH-1:0] coef_data,
   output pixel_t pixel_out,
   output logic out_valid,
   output logic out_last,
   output logic frame_done
);

   localparam int NP  = KERNEL_SIZE * KERNEL_SIZE;
   localparam int CTR = NP / 2;
   localparam int PW  = COEF_WIDTH + 9;
   localparam int AW  = PW + $clog2(NP);
   localparam int SW  = AW + 1;
   localparam int RND = (1 << SHIFT) >> 1;

   logic complete, last;
   logic signed [COEF_WIDTH-1:0] coef [NP];
   logic signed [PW-1:0] prod [NP];
   logic s1_v, s1_last, s2_v, s2_last;
   logic signed [AW-1:0] sum_c, s2_sum;
   logic signed [SW-1:0] biased, shifted;
   pixel_t pix_c;

   conv_raster_tracker #(
      .KERNEL_SIZE(KERNEL_SIZE),
      .ROW_WIDTH  (ROW_WIDTH),
      .COL_HEIGHT (COL_HEIGHT)
   ) u_tracker (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .frame_start(frame_start),
      .complete   (complete),
      .last       (last),
      .frame_done (frame_done)
   );

   // Bank reads happen before the write lands, so a same-cycle beat sees old values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NP; i++)
            coef[i] <= (i == CTR) ? COEF_WIDTH'(1 << SHIFT) : '0;
      end else if (coef_we && (32'(coef_addr) < NP)) begin
         coef[coef_addr] <= coef_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_v    <= 1'b0;
         s1_last <= 1'b0;
         for (int i = 0; i < NP; i++)
            prod[i] <= '0;
      end else begin
         s1_v    <= complete;
         s1_last <= complete & last;
         for (int r = 0; r < KERNEL_SIZE; r++)
            for (int c = 0; c < KERNEL_SIZE; c++)
               prod[r*KERNEL_SIZE+c] <=
                  PW'($signed({1'b0, window[r][c]})) *
                  PW'(coef[r*KERNEL_SIZE+c]);
      end
   end

   always_comb begin
      sum_c = '0;
      for (int i = 0; i < NP; i++)
         sum_c = sum_c + AW'(prod[i]);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_v    <= 1'b0;
         s2_last <= 1'b0;
         s2_sum  <= '0;
      end else begin
         s2_v    <= s1_v;
         s2_last <= s1_last;
         s2_sum  <= sum_c;
      end
   end

   always_comb begin
`ifdef CONV_ROUND_EN
      biased = SW'(s2_sum) + SW'(RND);
`else
      biased = SW'(s2_sum);
`endif
      shifted = biased >>> SHIFT;
      pix_c   = sat_u8(32'(shifted));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pixel_out <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         pixel_out <= pix_c;
         out_valid <= s2_v;
         out_last  <= s2_v & s2_last;
      end
   end

endmodule

// File: tb/tb_conv_window_mac.sv
// Directed bench for conv_window_mac: one SHIFT=4 and one SHIFT=0 instance
// sharing stimulus on a 5x5 frame.
module tb_conv_window_mac;

   localparam int K  = 3;
   localparam int RW = 5;
   localparam int CH = 5;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [K-1:0][K-1:0][7:0] window;
   logic in_valid, frame_start, coef_we;
   logic [3:0] coef_addr;
   logic [7:0] coef_data;
   logic [7:0] pix4, pix0;
   logic ov4, ov0, ol4, ol0, fd4, fd0;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int q_pix[$];
   int q_last[$];
   int q_cyc[$];
   int q0_pix[$];
   int fd_cyc[$];
   int b22, lastc, ref_c;

   conv_window_mac #(
      .KERNEL_SIZE(K), .ROW_WIDTH(RW), .COL_HEIGHT(CH),
      .COEF_WIDTH(8), .SHIFT(4)
   ) dut (
      .clk(clk), .reset(reset), .window(window),
      .in_valid(in_valid), .frame_start(frame_start),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .pixel_out(pix4), .out_valid(ov4), .out_last(ol4),
      .frame_done(fd4)
   );

   conv_window_mac #(
      .KERNEL_SIZE(K), .ROW_WIDTH(RW), .COL_HEIGHT(CH),
      .COEF_WIDTH(8), .SHIFT(0)
   ) dut0 (
      .clk(clk), .reset(reset), .window(window),
      .in_valid(in_valid), .frame_start(frame_start),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .pixel_out(pix0), .out_valid(ov0), .out_last(ol0),
      .frame_done(fd0)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (ov4) begin
         q_pix.push_back(int'(pix4));
         q_last.push_back(int'(ol4));
         q_cyc.push_back(cyc);
      end
      if (ov0) q0_pix.push_back(int'(pix0));
      if (fd4) fd_cyc.push_back(cyc);
   end

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      frame_start = 1'b0;
      coef_we = 1'b0;
      repeat (n) step();
   endtask

   task automatic fill(input int v);
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            window[r][c] = 8'(v);
   endtask

   task automatic beat();
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      frame_start = 1'b0;
      coef_we = 1'b0;
   endtask

   task automatic wr_coef(input int a, input int d);
      coef_we = 1'b1;
      coef_addr = 4'(a);
      coef_data = 8'(d);
      step();
      coef_we = 1'b0;
   endtask

   task automatic to_complete();
      frame_start = 1'b1;
      in_valid = 1'b0;
      step();
      frame_start = 1'b0;
      fill(0);
      repeat (12) beat();
   endtask

   task automatic clear_q();
      q_pix.delete();
      q_last.delete();
      q_cyc.delete();
      q0_pix.delete();
      fd_cyc.delete();
   endtask

   initial begin
      window = '0;
      in_valid = 1'b0;
      frame_start = 1'b0;
      coef_we = 1'b0;
      coef_addr = '0;
      coef_data = '0;

      step();
      step();
      check("rst_pixel", int'(pix4), 0);
      check("rst_valid", int'(ov4), 0);
      check("rst_last", int'(ol4), 0);
      check("rst_fdone", int'(fd4), 0);
      check("rst_valid0", int'(ov0), 0);
      reset = 1'b1;
      step();

      // identity kernel over a full 5x5 frame, centre pixel = raster index
      clear_q();
      for (int idx = 0; idx < RW * CH; idx++) begin
         fill(200);
         window[1][1] = 8'(idx);
         frame_start = (idx == 0);
         if (idx == 12) b22 = cyc;
         if (idx == 24) lastc = cyc;
         beat();
      end
      idle(5);
      check("id_count", q_pix.size(), 9);
      for (int j = 0; j < 9; j++) begin
         check("id_pixel", q_pix[j], (2 + j / 3) * RW + 2 + j % 3);
         check("id_last", q_last[j], (j == 8) ? 1 : 0);
      end
      check("id_latency", q_cyc[0], b22 + 3);
      check("fd_count", fd_cyc.size(), 1);
      check("fd_cycle", fd_cyc[0], lastc + 1);

      // all coefficients 1: saturation high and ramp sums
      for (int a = 0; a < 9; a++) wr_coef(a, 1);
      wr_coef(9, 100);
      wr_coef(15, 100);
      to_complete();
      clear_q();
      fill(255);
      beat();
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            window[r][c] = 8'(r * K + c);
      beat();
      window[2][2] = 8'd12;
      beat();
      idle(5);
      check("ones_count", q_pix.size(), 3);
      check("sat_hi_s0", q0_pix[0], 255);
      check("ones255_s4", q_pix[0], 143);
      check("sum36_s4", q_pix[1], 2);
      check("sum36_s0", q0_pix[1], 36);
`ifdef CONV_ROUND_EN
      check("sum40_s4", q_pix[2], 3);
`else
      check("sum40_s4", q_pix[2], 2);
`endif
      check("sum40_s0", q0_pix[2], 40);

      // negative kernel saturates low
      for (int a = 0; a < 9; a++) wr_coef(a, (a == 4) ? 8'hFF : 0);
      to_complete();
      clear_q();
      fill(10);
      beat();
      idle(5);
      check("neg_count", q_pix.size(), 1);
      check("neg_s4", q_pix[0], 0);
      check("neg_s0", q0_pix[0], 0);

      // coefficient write in the same cycle as a complete beat
      wr_coef(4, 16);
      to_complete();
      clear_q();
      fill(50);
      coef_we = 1'b1;
      coef_addr = 4'd4;
      coef_data = 8'd32;
      beat();
      beat();
      idle(5);
      check("cw_count", q_pix.size(), 2);
      check("cw_old", q_pix[0], 50);
      check("cw_new", q_pix[1], 100);

      // reset with two results in flight
      to_complete();
      clear_q();
      fill(60);
      beat();
      beat();
      reset = 1'b0;
      #2;
      check("rr_valid", int'(ov4), 0);
      step();
      reset = 1'b1;
      idle(5);
      check("rr_drop", q_pix.size(), 0);
      check("rr_drop0", q0_pix.size(), 0);

      // first post-reset frame: counters from (0,0), identity coefficients
      clear_q();
      fill(77);
      for (int i = 0; i < 13; i++) begin
         if (i == 12) ref_c = cyc;
         beat();
      end
      idle(5);
      check("pr_count", q_pix.size(), 1);
      check("pr_pixel", q_pix[0], 77);
      check("pr_pixel0", q0_pix[0], 77);
      check("pr_latency", q_cyc[0], ref_c + 3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
